// File: rtl/user_update_reg_if.sv
// Bundles the JTAG TAP-side strobes and the committed control-bus outputs of
// user_update_reg; the master modport is the TAP/host side, slave is the register.
interface user_update_reg_if #(
    parameter int width = 8
);
    logic             SEL;
    logic             FUPD;
    logic             TDI;
    logic             CAPTURE;
    logic             SHIFT;
    logic             UPDATE;
    logic             TDO;
    logic [width-1:0] DATA;
    logic             STRB;
    logic             LEN_ERR;

    modport master (
        output SEL, FUPD, TDI, CAPTURE, SHIFT, UPDATE,
        input  TDO, DATA, STRB, LEN_ERR
    );

    modport slave (
        input  SEL, FUPD, TDI, CAPTURE, SHIFT, UPDATE,
        output TDO, DATA, STRB, LEN_ERR
    );
endinterface

// File: rtl/user_update_reg.sv
// JTAG serial-in/parallel-out user update register: commits a scanned word to DATA
// with a one-cycle STRB. Define USER_UPDATE_LENCHK_EN to reject scans of the wrong length.
module user_update_reg #(
    parameter int               width   = 8,
    parameter logic [width-1:0] DEFAULT = {width{1'b0}}
) (
    input  logic              DRCK,
    input  logic              RST_N,
    user_update_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SHIFTING = 2'd2
    } state_t;

    logic       ce;
    state_t     st_q, st_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] data_q, data_d;
    logic       strb_q, strb_d;

`ifdef USER_UPDATE_LENCHK_EN
    localparam int CNT_W = $clog2(width + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(width);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(width + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lenerr_q, lenerr_d;
`endif

    assign ce = bus.SEL & bus.FUPD;

    always_comb begin
        st_d   = st_q;
        q_d    = q_q;
        data_d = data_q;
        strb_d = 1'b0;
`ifdef USER_UPDATE_LENCHK_EN
        cnt_d    = cnt_q;
        lenerr_d = lenerr_q;
`endif
        if (ce) begin
            if (bus.CAPTURE) begin
                // Preload the live setting so TDO reads back the old value during the scan
                st_d = ARMED;
                q_d  = data_q;
`ifdef USER_UPDATE_LENCHK_EN
                cnt_d    = '0;
                lenerr_d = 1'b0;
`endif
            end else if (bus.SHIFT && st_q != IDLE) begin
                st_d = SHIFTING;
                q_d  = {bus.TDI, q_q[width-1:1]};
`ifdef USER_UPDATE_LENCHK_EN
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`endif
            end else if (bus.UPDATE && st_q != IDLE) begin
                st_d = IDLE;
`ifdef USER_UPDATE_LENCHK_EN
                if (cnt_q == CNT_FULL) begin
                    data_d   = q_q;
                    strb_d   = 1'b1;
                    lenerr_d = 1'b0;
                end else begin
                    lenerr_d = 1'b1;
                end
`else
                data_d = q_q;
                strb_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge DRCK) begin
        if (!RST_N) begin
            st_q   <= IDLE;
            q_q    <= '0;
            data_q <= DEFAULT;
            strb_q <= 1'b0;
`ifdef USER_UPDATE_LENCHK_EN
            cnt_q    <= '0;
            lenerr_q <= 1'b0;
`endif
        end else begin
            st_q   <= st_d;
            q_q    <= q_d;
            data_q <= data_d;
            strb_q <= strb_d;
`ifdef USER_UPDATE_LENCHK_EN
            cnt_q    <= cnt_d;
            lenerr_q <= lenerr_d;
`endif
        end
    end

    assign bus.TDO  = ce & q_q[0];
    assign bus.DATA = data_q;
    assign bus.STRB = strb_q;
`ifdef USER_UPDATE_LENCHK_EN
    assign bus.LEN_ERR = lenerr_q;
`else
    assign bus.LEN_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_user_update_reg.sv
// Directed bench for user_update_reg (width=8, DEFAULT=8'hA5); expectations follow
// whichever build USER_UPDATE_LENCHK_EN selects.
module tb_user_update_reg;
    logic DRCK;
    logic RST_N;
    int   n_checks;
    int   n_errors;
    logic [15:0] rb;

    user_update_reg_if #(.width(8)) u_if ();

    user_update_reg #(
        .width   (8),
        .DEFAULT (8'hA5)
    ) dut (
        .DRCK  (DRCK),
        .RST_N (RST_N),
        .bus   (u_if.slave)
    );

    initial DRCK = 1'b0;
    always #5 DRCK = ~DRCK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge DRCK);
        #1;
    endtask

    task automatic do_capture();
        u_if.CAPTURE = 1'b1;
        tick();
        u_if.CAPTURE = 1'b0;
    endtask

    // Shifts n bits of w LSB-first, recording the TDO bit seen before each edge
    task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] tdo_bits);
        tdo_bits = '0;
        for (int i = 0; i < n; i++) begin
            tdo_bits[i] = u_if.TDO;
            u_if.TDI    = w[i];
            u_if.SHIFT  = 1'b1;
            tick();
        end
        u_if.SHIFT = 1'b0;
        u_if.TDI   = 1'b0;
    endtask

    task automatic do_update();
        u_if.UPDATE = 1'b1;
        tick();
        u_if.UPDATE = 1'b0;
    endtask

    task automatic do_reset(input int edges);
        RST_N = 1'b0;
        for (int i = 0; i < edges; i++) tick();
        RST_N = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST_N = 1'b0;
        u_if.SEL = 1'b1;
        u_if.FUPD = 1'b1;
        u_if.TDI = 1'b0;
        u_if.CAPTURE = 1'b0;
        u_if.SHIFT = 1'b0;
        u_if.UPDATE = 1'b0;

        // Reset
        do_reset(2);
        check("rst_data", 32'(u_if.DATA), 32'hA5);
        check("rst_strb", 32'(u_if.STRB), 0);
        check("rst_lenerr", 32'(u_if.LEN_ERR), 0);
        check("rst_tdo", 32'(u_if.TDO), 0);

        // Five ones then UPDATE: commit only in the unchecked build
        do_capture();
        shift_bits(16'h001F, 5, rb);
        do_update();
`ifdef USER_UPDATE_LENCHK_EN
        check("five_data", 32'(u_if.DATA), 32'hA5);
        check("five_strb", 32'(u_if.STRB), 0);
        check("five_lenerr", 32'(u_if.LEN_ERR), 1);
`else
        check("five_data", 32'(u_if.DATA), 32'hFD);
        check("five_strb", 32'(u_if.STRB), 1);
        check("five_lenerr", 32'(u_if.LEN_ERR), 0);
`endif
        do_reset(1);
        check("rst2_data", 32'(u_if.DATA), 32'hA5);

        // Good 8-bit write of 3C with readback of A5
        do_capture();
        check("cap_tdo", 32'(u_if.TDO), 1);
        shift_bits(16'h003C, 8, rb);
        check("good_readback", 32'(rb[7:0]), 32'hA5);
        do_update();
        check("good_data", 32'(u_if.DATA), 32'h3C);
        check("good_strb", 32'(u_if.STRB), 1);
        check("good_lenerr", 32'(u_if.LEN_ERR), 0);
        tick();
        check("good_strb_fall", 32'(u_if.STRB), 0);

        // Short scan: 7 ones
        do_capture();
        shift_bits(16'h007F, 7, rb);
        check("short_readback", 32'(rb[6:0]), 32'h3C);
        do_update();
`ifdef USER_UPDATE_LENCHK_EN
        check("short_data", 32'(u_if.DATA), 32'h3C);
        check("short_strb", 32'(u_if.STRB), 0);
        check("short_lenerr", 32'(u_if.LEN_ERR), 1);
`else
        check("short_data", 32'(u_if.DATA), 32'hFE);
        check("short_strb", 32'(u_if.STRB), 1);
        check("short_lenerr", 32'(u_if.LEN_ERR), 0);
`endif
        tick();

        // Good write of 5A clears the error
        do_capture();
        check("clr_lenerr_cap", 32'(u_if.LEN_ERR), 0);
        shift_bits(16'h005A, 8, rb);
        do_update();
        check("clr_data", 32'(u_if.DATA), 32'h5A);
        check("clr_lenerr", 32'(u_if.LEN_ERR), 0);
        tick();

        // Long scan: 10 bits of 0x369
        do_capture();
        shift_bits(16'h0369, 10, rb);
`ifdef USER_UPDATE_LENCHK_EN
        check("long_cnt_sat", 32'(dut.cnt_q), 9);
`endif
        do_update();
`ifdef USER_UPDATE_LENCHK_EN
        check("long_data", 32'(u_if.DATA), 32'h5A);
        check("long_strb", 32'(u_if.STRB), 0);
        check("long_lenerr", 32'(u_if.LEN_ERR), 1);
`else
        check("long_data", 32'(u_if.DATA), 32'hDA);
        check("long_strb", 32'(u_if.STRB), 1);
`endif
        tick();

        // FUPD gated for 3 cycles mid-scan, then resume to 8 bits of 96
        do_capture();
        shift_bits(16'h0006, 4, rb);
        u_if.FUPD = 1'b0;
        u_if.SHIFT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.TDI = i[0];
            tick();
            check("gate_tdo", 32'(u_if.TDO), 0);
            check("gate_strb", 32'(u_if.STRB), 0);
        end
        u_if.SHIFT = 1'b0;
        u_if.FUPD = 1'b1;
        shift_bits(16'h0009, 4, rb);
        do_update();
        check("gate_data", 32'(u_if.DATA), 32'h96);
        check("gate_strb_upd", 32'(u_if.STRB), 1);
        check("gate_lenerr", 32'(u_if.LEN_ERR), 0);
        tick();

        // Zero-length update straight from ARMED
        do_capture();
        do_update();
`ifdef USER_UPDATE_LENCHK_EN
        check("zero_strb", 32'(u_if.STRB), 0);
        check("zero_lenerr", 32'(u_if.LEN_ERR), 1);
`else
        check("zero_strb", 32'(u_if.STRB), 1);
`endif
        check("zero_data", 32'(u_if.DATA), 32'h96);
        tick();

        // Reset after 4 shifts, then an UPDATE from IDLE must do nothing
        do_capture();
        shift_bits(16'h000F, 4, rb);
        do_reset(1);
        check("midrst_data", 32'(u_if.DATA), 32'hA5);
        check("midrst_st", 32'(dut.st_q), 0);
        check("midrst_lenerr", 32'(u_if.LEN_ERR), 0);
        do_update();
        check("idle_upd_strb", 32'(u_if.STRB), 0);
        check("idle_upd_data", 32'(u_if.DATA), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
